// File: rtl/i3c_target_addr_responder_pkg.sv
// ---------------------------------------------------------------------------
// i3c_target_addr_responder_pkg
//   Shared constants and types for the I3C target addressing blocks.
//   - ADDR_WIDTH       : I3C address field width (7 bits, fixed by protocol)
//   - I3C_BCAST_ADDR   : broadcast address 7'h7E
//   - TGT_STATE_WIDTH  : width of the target FSM state encoding
//   - tgt_state_e      : TGT_IDLE / TGT_ADDR / TGT_ACK / TGT_XFER / TGT_IGNORE
// ---------------------------------------------------------------------------
package i3c_target_addr_responder_pkg;

  localparam int unsigned ADDR_WIDTH      = 7;
  localparam int unsigned HDR_WIDTH       = ADDR_WIDTH + 1;
  localparam int unsigned TGT_STATE_WIDTH = 3;

  localparam logic [ADDR_WIDTH-1:0] I3C_BCAST_ADDR = 7'h7E;

  typedef enum logic [TGT_STATE_WIDTH-1:0] {
    TGT_IDLE   = 3'd0,
    TGT_ADDR   = 3'd1,
    TGT_ACK    = 3'd2,
    TGT_XFER   = 3'd3,
    TGT_IGNORE = 3'd4
  } tgt_state_e;

endpackage

// File: rtl/i3c_target_addr_responder_bus_cond_detect.sv
// ---------------------------------------------------------------------------
// i3c_bus_cond_detect
//   Synchronises raw SCL/SDA into clk_i, keeps one history flop per line and
//   derives START/Sr, STOP and SCL edge indications. Pulses are combinational
//   decodes of flops only (no raw-input paths), one clk wide, and appear
//   SYNC_STAGES+1 clk after the bus transition once registered by the user.
//   Ports:
//     clk_i, rst_ni   : clock, asynchronous active-low reset
//     scl_i, sda_i    : raw bus lines
//     sda_o           : synchronised SDA level
//     start_o, stop_o : START/Sr and STOP conditions
//     scl_rise_o      : synchronised SCL 0->1 (bit sample point)
//     scl_fall_o      : synchronised SCL 1->0
// ---------------------------------------------------------------------------
module i3c_bus_cond_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_hist_r;
  logic                   sda_hist_r;
  logic                   scl_s;
  logic                   sda_s;

  // Synchroniser chains plus history flops; reset to 1 so an idle bus is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
      scl_hist_r <= scl_sync_r[SYNC_STAGES-1];
      sda_hist_r <= sda_sync_r[SYNC_STAGES-1];
    end
  end

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  // SDA edges only count as conditions while SCL is stably high.
  assign start_o    = sda_hist_r & ~sda_s & scl_s & scl_hist_r;
  assign stop_o     = ~sda_hist_r & sda_s & scl_s & scl_hist_r;
  assign scl_rise_o = ~scl_hist_r & scl_s;
  assign scl_fall_o = scl_hist_r & ~scl_s;
  assign sda_o      = sda_s;

endmodule

// File: rtl/i3c_target_addr_responder.sv
// ---------------------------------------------------------------------------
// i3c_target_addr_responder
//   Target-side address header receiver. Detects START/Sr/STOP, shifts in the
//   8-bit header (7-bit address + RnW), compares it against the dynamic
//   address (or STATIC_ADDR when none is assigned) and drives the ACK slot via
//   an open-drain enable. All outputs are registered.
//   Optional feature: define I3C_TGT_BROADCAST_EN to accept header 7'h7E
//   (either RnW) whenever enabled and flag it on bcast_o.
//   Ports:
//     clk_i, rst_ni          : clock, asynchronous active-low reset
//     scl_i, sda_i           : raw bus lines
//     enable_i               : target enabled (never ACKs when 0)
//     dyn_addr_i/_valid_i    : assigned dynamic address and its valid flag
//     sda_oe_o               : 1 = pull SDA low
//     rx_addr_o, rnw_o       : last received address field and RnW bit
//     addr_match_o           : matched transaction active
//     match_pulse_o          : ACK committed (1 clk)
//     bcast_o                : matched header was the broadcast address
//     start_det_o/stop_det_o : START-or-Sr / STOP pulses
//     busy_o                 : bus between START and STOP
// ---------------------------------------------------------------------------
module i3c_target_addr_responder
  import i3c_target_addr_responder_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] STATIC_ADDR = 7'h50,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  scl_i,
  input  logic                  sda_i,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] dyn_addr_i,
  input  logic                  dyn_addr_valid_i,
  output logic                  sda_oe_o,
  output logic [ADDR_WIDTH-1:0] rx_addr_o,
  output logic                  rnw_o,
  output logic                  addr_match_o,
  output logic                  match_pulse_o,
  output logic                  bcast_o,
  output logic                  start_det_o,
  output logic                  stop_det_o,
  output logic                  busy_o
);

  logic                  sda_s;
  logic                  start_s;
  logic                  stop_s;
  logic                  scl_rise_s;
  logic                  scl_fall_s;
  logic [HDR_WIDTH-1:0]  hdr_next_s;
  logic [ADDR_WIDTH-1:0] rx_next_s;
  logic                  ucast_hit_s;
  logic                  bcast_hit_s;

  tgt_state_e            state_r;
  logic [3:0]            bit_cnt_r;
  logic [ADDR_WIDTH-1:0] shift_r;
  logic                  match_pend_r;
  logic                  bcast_pend_r;

  i3c_bus_cond_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_bus_cond (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .start_o    (start_s),
    .stop_o     (stop_s),
    .scl_rise_o (scl_rise_s),
    .scl_fall_o (scl_fall_s)
  );

  assign hdr_next_s = {shift_r, sda_s};
  assign rx_next_s  = hdr_next_s[HDR_WIDTH-1:1];

  // Match decode for the header completed by the current sample; only
  // consumed on the 8th bit, which is where enable/address inputs are sampled.
  always_comb begin
    ucast_hit_s = 1'b0;
    bcast_hit_s = 1'b0;
    if (dyn_addr_valid_i) begin
      ucast_hit_s = enable_i & (rx_next_s == dyn_addr_i);
    end else begin
      ucast_hit_s = enable_i & (rx_next_s == STATIC_ADDR);
    end
`ifdef I3C_TGT_BROADCAST_EN
    bcast_hit_s = enable_i & (rx_next_s == I3C_BCAST_ADDR);
`else
    bcast_hit_s = 1'b0;
`endif
  end

  // Target FSM with registered outputs; STOP beats START beats SCL edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= TGT_IDLE;
      bit_cnt_r     <= 4'd0;
      shift_r       <= '0;
      match_pend_r  <= 1'b0;
      bcast_pend_r  <= 1'b0;
      sda_oe_o      <= 1'b0;
      rx_addr_o     <= '0;
      rnw_o         <= 1'b0;
      addr_match_o  <= 1'b0;
      match_pulse_o <= 1'b0;
      bcast_o       <= 1'b0;
      start_det_o   <= 1'b0;
      stop_det_o    <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      match_pulse_o <= 1'b0;
      start_det_o   <= start_s;
      stop_det_o    <= stop_s;
      if (stop_s) begin
        state_r      <= TGT_IDLE;
        bit_cnt_r    <= 4'd0;
        sda_oe_o     <= 1'b0;
        addr_match_o <= 1'b0;
        bcast_o      <= 1'b0;
        busy_o       <= 1'b0;
      end else if (start_s) begin
        // START from IDLE and Sr from any other state behave identically.
        state_r      <= TGT_ADDR;
        bit_cnt_r    <= 4'd0;
        shift_r      <= '0;
        sda_oe_o     <= 1'b0;
        addr_match_o <= 1'b0;
        bcast_o      <= 1'b0;
        busy_o       <= 1'b1;
      end else begin
        case (state_r)
          TGT_IDLE: begin
            state_r <= TGT_IDLE;
          end
          TGT_ADDR: begin
            if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
              shift_r   <= hdr_next_s[ADDR_WIDTH-1:0];
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                rx_addr_o    <= rx_next_s;
                rnw_o        <= hdr_next_s[0];
                match_pend_r <= ucast_hit_s | bcast_hit_s;
                bcast_pend_r <= bcast_hit_s;
              end else begin
                match_pend_r <= 1'b0;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              // ACK slot opens on the fall after RnW.
              if (match_pend_r) begin
                state_r       <= TGT_ACK;
                sda_oe_o      <= 1'b1;
                match_pulse_o <= 1'b1;
                addr_match_o  <= 1'b1;
                bcast_o       <= bcast_pend_r;
              end else begin
                state_r  <= TGT_IGNORE;
                sda_oe_o <= 1'b0;
              end
            end else begin
              state_r <= TGT_ADDR;
            end
          end
          TGT_ACK: begin
            if (scl_fall_s) begin
              sda_oe_o <= 1'b0;
              state_r  <= TGT_XFER;
            end else begin
              sda_oe_o <= 1'b1;
            end
          end
          TGT_XFER: begin
            state_r <= TGT_XFER;
          end
          TGT_IGNORE: begin
            sda_oe_o <= 1'b0;
          end
          default: begin
            state_r  <= TGT_IDLE;
            sda_oe_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
